// File: rtl/wb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : wb_reg_file
// Brief    : 2^ADDR_WIDTH x DATA_WIDTH register file with r0 fixed at zero.
//            Two combinational reads with same-cycle write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module wb_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [ADDR_WIDTH-1:0] ReadReg1_In,
    input  logic [ADDR_WIDTH-1:0] ReadReg2_In,
    input  logic [ADDR_WIDTH-1:0] WriteReg_In,
    input  logic [DATA_WIDTH-1:0] WriteData_In,
    input  logic                  RegWrite_In,
    output logic [DATA_WIDTH-1:0] ReadData1_Out,
    output logic [DATA_WIDTH-1:0] ReadData2_Out
);

    localparam int c_NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // A write to index 0 is dropped here so r_regs[0] never leaves its reset value.
    assign w_wr_en = RegWrite_In && (WriteReg_In != '0);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[WriteReg_In] <= WriteData_In;
        end
    end

    // Reads are forced to zero while in reset, even if a bypass would apply.
    always_comb begin
        w_rd1 = '0;
        if (!Rst && (ReadReg1_In != '0)) begin
            if (RegWrite_In && (WriteReg_In == ReadReg1_In)) begin
                w_rd1 = WriteData_In;
            end else begin
                w_rd1 = r_regs[ReadReg1_In];
            end
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (!Rst && (ReadReg2_In != '0)) begin
            if (RegWrite_In && (WriteReg_In == ReadReg2_In)) begin
                w_rd2 = WriteData_In;
            end else begin
                w_rd2 = r_regs[ReadReg2_In];
            end
        end
    end

    assign ReadData1_Out = w_rd1;
    assign ReadData2_Out = w_rd2;

endmodule
`default_nettype wire
